wb_commit_queue: RTL and testbench

WB_COMMIT_QUEUE -- requirements
Module: wb_commit_queue

---
 rtl/wb_commit_queue.sv | 121 ++++++++++++
 tb/tb_wb_commit_queue.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_commit_queue.sv
// Purpose: writeback commit queue; buffers up to two results per cycle and drains two per cycle to the register file.
// Latency: an entry enqueued at edge N is presented on the write ports in the cycle after edge N.
// Backpressure: in_ready drops when fewer than two free slots remain; upstream holds its lane pair until in_ready returns.
module wb_commit_queue #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_validA,
    input  logic                     in_validB,
    input  logic [4:0]               in_addrA,
    input  logic [4:0]               in_addrB,
    input  logic [31:0]              in_dataA,
    input  logic [31:0]              in_dataB,
    output logic                     in_ready,
    input  logic                     drain_en,
    input  logic                     flush,
    output logic                     weA,
    output logic                     weB,
    output logic [4:0]               waA,
    output logic [4:0]               waB,
    output logic [31:0]              wdA,
    output logic [31:0]              wdB,
    input  logic [4:0]               ra1A,
    input  logic [4:0]               ra2A,
    input  logic [4:0]               ra1B,
    input  logic [4:0]               ra2B,
    output logic                     pend1A,
    output logic                     pend2A,
    output logic                     pend1B,
    output logic                     pend2B,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [4:0]    mem_a [DEPTH];
    logic [31:0]   mem_d [DEPTH];
    logic [PW-1:0] head, tail, head1, tail_b;
    logic [CW-1:0] count_q;
    logic          do_enq, qa, qb;
    logic [1:0]    n_enq, n_drn;
    logic [DEPTH-1:0] vld;
    logic [PW-1:0] offs [DEPTH];
    logic          m1a, m2a, m1b, m2b;

    assign count    = count_q;
    assign in_ready = (CW'(DEPTH) - count_q) >= CW'(2);

    assign weA = drain_en && !flush && (count_q >= CW'(1));
    assign weB = drain_en && !flush && (count_q >= CW'(2));

    assign head1 = head + 1'b1;
    assign waA   = mem_a[head];
    assign wdA   = mem_d[head];
    assign waB   = mem_a[head1];
    assign wdB   = mem_d[head1];

    // Writes to r0 are architecturally dead, so they never take a slot.
    assign do_enq = in_ready && !flush;
    assign qa     = do_enq && in_validA && (in_addrA != 5'd0);
    assign qb     = do_enq && in_validB && (in_addrB != 5'd0);
    assign tail_b = qa ? tail + 1'b1 : tail;
    assign n_enq  = {1'b0, qa} + {1'b0, qb};
    assign n_drn  = {1'b0, weA} + {1'b0, weB};

    // An entry is live when its distance from head is below count; this still covers entries draining now.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            offs[i] = PW'(i) - head;
            vld[i]  = {1'b0, offs[i]} < count_q;
        end
    end

    always_comb begin
        m1a = 1'b0;
        m2a = 1'b0;
        m1b = 1'b0;
        m2b = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (vld[i]) begin
                if (mem_a[i] == ra1A) m1a = 1'b1;
                if (mem_a[i] == ra2A) m2a = 1'b1;
                if (mem_a[i] == ra1B) m1b = 1'b1;
                if (mem_a[i] == ra2B) m2b = 1'b1;
            end
        end
    end

    assign pend1A = m1a && (ra1A != 5'd0);
    assign pend2A = m2a && (ra2A != 5'd0);
    assign pend1B = m1b && (ra1B != 5'd0);
    assign pend2B = m2b && (ra2B != 5'd0);

    always_ff @(posedge clk) begin
        if (qa) begin
            mem_a[tail] <= in_addrA;
            mem_d[tail] <= in_dataA;
        end
        if (qb) begin
            mem_a[tail_b] <= in_addrB;
            mem_d[tail_b] <= in_dataB;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else if (flush) begin
            head    <= '0;
            tail    <= '0;
            count_q <= '0;
        end else begin
            head    <= head + PW'(n_drn);
            tail    <= tail + PW'(n_enq);
            count_q <= count_q + CW'(n_enq) - CW'(n_drn);
        end
    end
endmodule

// File: tb/tb_wb_commit_queue.sv
// Bench for wb_commit_queue: queue-based reference model checked every negedge plus directed literal checks.
module tb_wb_commit_queue;
    localparam int DEPTH = 8;

    logic        clk, rst_n;
    logic        in_validA, in_validB, in_ready, drain_en, flush;
    logic [4:0]  in_addrA, in_addrB, waA, waB, ra1A, ra2A, ra1B, ra2B;
    logic [31:0] in_dataA, in_dataB, wdA, wdB;
    logic        weA, weB, pend1A, pend2A, pend1B, pend2B;
    logic [3:0]  count;

    wb_commit_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_validA(in_validA), .in_validB(in_validB),
        .in_addrA(in_addrA), .in_addrB(in_addrB),
        .in_dataA(in_dataA), .in_dataB(in_dataB),
        .in_ready(in_ready), .drain_en(drain_en), .flush(flush),
        .weA(weA), .weB(weB), .waA(waA), .waB(waB), .wdA(wdA), .wdB(wdB),
        .ra1A(ra1A), .ra2A(ra2A), .ra1B(ra1B), .ra2B(ra2B),
        .pend1A(pend1A), .pend2A(pend2A), .pend1B(pend1B), .pend2B(pend2B),
        .count(count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] rf [32];
    int          n_chk = 0;
    int          n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit hit(input logic [4:0] ra);
        if (ra == 5'd0) return 1'b0;
        foreach (mq[i]) if (mq[i].a == ra) return 1'b1;
        return 1'b0;
    endfunction

    // Reference model: a plain FIFO of pending writes plus a register-file image.
    always @(posedge clk or negedge rst_n) begin : mdl
        int n;
        bit da, db, rdy;
        ent_t e;
        if (!rst_n) begin
            mq.delete();
        end else begin
            n   = mq.size();
            da  = drain_en && !flush && n >= 1;
            db  = drain_en && !flush && n >= 2;
            rdy = (DEPTH - n) >= 2;
            if (flush) begin
                mq.delete();
            end else begin
                if (da) begin rf[mq[0].a] = mq[0].d; void'(mq.pop_front()); end
                if (db) begin rf[mq[0].a] = mq[0].d; void'(mq.pop_front()); end
                if (rdy && in_validA && in_addrA != 5'd0) begin
                    e.a = in_addrA; e.d = in_dataA; mq.push_back(e);
                end
                if (rdy && in_validB && in_addrB != 5'd0) begin
                    e.a = in_addrB; e.d = in_dataB; mq.push_back(e);
                end
            end
        end
    end

    always @(negedge clk) begin : cmp
        int  n;
        bit  ea, eb;
        n  = mq.size();
        ea = rst_n && drain_en && !flush && n >= 1;
        eb = rst_n && drain_en && !flush && n >= 2;
        chk("count", 32'(count), 32'(n));
        chk("in_ready", 32'(in_ready), 32'((DEPTH - n) >= 2));
        chk("weA", 32'(weA), 32'(ea));
        chk("weB", 32'(weB), 32'(eb));
        if (ea && weA) begin
            chk("waA", 32'(waA), 32'(mq[0].a));
            chk("wdA", wdA, mq[0].d);
        end
        if (eb && weB) begin
            chk("waB", 32'(waB), 32'(mq[1].a));
            chk("wdB", wdB, mq[1].d);
        end
        chk("pend1A", 32'(pend1A), 32'(hit(ra1A)));
        chk("pend2A", 32'(pend2A), 32'(hit(ra2A)));
        chk("pend1B", 32'(pend1B), 32'(hit(ra1B)));
        chk("pend2B", 32'(pend2B), 32'(hit(ra2B)));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic lanes(input logic va, input logic [4:0] aa, input logic [31:0] da,
                         input logic vb, input logic [4:0] ab, input logic [31:0] db);
        in_validA = va; in_addrA = aa; in_dataA = da;
        in_validB = vb; in_addrB = ab; in_dataB = db;
    endtask

    initial begin
        rst_n = 1'b0; drain_en = 1'b0; flush = 1'b0;
        lanes(0, 0, 0, 0, 0, 0);
        ra1A = 0; ra2A = 0; ra1B = 0; ra2B = 0;
        #1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_weA", 32'(weA), 32'd0);
        tick(); tick();
        rst_n = 1'b1;

        // Single write on lane A.
        lanes(1, 5, 32'h11, 0, 0, 0); drain_en = 1'b1;
        tick(); lanes(0, 0, 0, 0, 0, 0); #1;
        chk("t1_weA", 32'(weA), 32'd1);
        chk("t1_waA", 32'(waA), 32'd5);
        chk("t1_wdA", wdA, 32'h11);
        chk("t1_weB", 32'(weB), 32'd0);
        chk("t1_cnt1", 32'(count), 32'd1);
        tick(); #1;
        chk("t1_cnt0", 32'(count), 32'd0);
        chk("t1_rf5", rf[5], 32'h11);

        // Same-register pair: B is newer and lands last.
        drain_en = 1'b0; lanes(1, 3, 32'hAA, 1, 3, 32'hBB);
        tick(); lanes(0, 0, 0, 0, 0, 0); drain_en = 1'b1; #1;
        chk("t2_waA", 32'(waA), 32'd3);
        chk("t2_wdA", wdA, 32'hAA);
        chk("t2_waB", 32'(waB), 32'd3);
        chk("t2_wdB", wdB, 32'hBB);
        tick(); #1;
        chk("t2_rf3", rf[3], 32'hBB);

        // Fill to DEPTH across the pointer wrap, then drain two per cycle.
        drain_en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            lanes(1, 5'(2*k+1), 32'h100 + 32'(2*k+1), 1, 5'(2*k+2), 32'h100 + 32'(2*k+2));
            tick();
        end
        #1;
        chk("t3_full_cnt", 32'(count), 32'd8);
        chk("t3_full_rdy", 32'(in_ready), 32'd0);
        lanes(1, 10, 32'hDEAD, 1, 11, 32'hBEEF);
        tick(); #1;
        chk("t3_held_cnt", 32'(count), 32'd8);
        lanes(0, 0, 0, 0, 0, 0); drain_en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("t3_ord_waA", 32'(waA), 32'(2*k+1));
            chk("t3_ord_waB", 32'(waB), 32'(2*k+2));
            tick();
        end
        drain_en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            lanes(1, 5'(20+2*k), 32'h200 + 32'(k), 1, 5'(21+2*k), 32'h300 + 32'(k));
            tick();
        end
        drain_en = 1'b1; lanes(1, 30, 32'h400, 1, 31, 32'h401);
        tick(); lanes(0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) tick();
        #1;
        chk("t3_empty", 32'(count), 32'd0);
        chk("t3_rf31", rf[31], 32'h401);

        // Pending hazard on r7.
        drain_en = 1'b0; lanes(1, 7, 32'h77, 0, 0, 0);
        tick(); lanes(0, 0, 0, 0, 0, 0); ra1A = 7; ra2B = 0; #1;
        chk("t4_pend1A", 32'(pend1A), 32'd1);
        chk("t4_pend2B", 32'(pend2B), 32'd0);
        drain_en = 1'b1; #1;
        chk("t4_pend_drain", 32'(pend1A), 32'd1);
        tick(); drain_en = 1'b0; #1;
        chk("t4_pend_after", 32'(pend1A), 32'd0);
        ra1A = 0;

        // r0 writes are dropped.
        lanes(1, 0, 32'hFF, 1, 9, 32'h1);
        tick(); lanes(0, 0, 0, 0, 0, 0); #1;
        chk("t5_cnt", 32'(count), 32'd1);
        drain_en = 1'b1; #1;
        chk("t5_waA", 32'(waA), 32'd9);
        chk("t5_weB", 32'(weB), 32'd0);
        tick(); drain_en = 1'b0; #1;
        chk("t5_rf9", rf[9], 32'h1);

        // Flush with five entries and live inputs.
        lanes(1, 1, 32'h501, 1, 2, 32'h502); tick();
        lanes(1, 3, 32'h503, 1, 4, 32'h504); tick();
        lanes(1, 5, 32'h505, 0, 0, 0); tick(); #1;
        chk("t6_cnt5", 32'(count), 32'd5);
        flush = 1'b1; drain_en = 1'b1; lanes(1, 6, 32'h506, 1, 7, 32'h507); ra1B = 4; #1;
        chk("t6_fl_weA", 32'(weA), 32'd0);
        chk("t6_fl_weB", 32'(weB), 32'd0);
        tick(); flush = 1'b0; drain_en = 1'b0; lanes(0, 0, 0, 0, 0, 0); #1;
        chk("t6_fl_cnt", 32'(count), 32'd0);
        chk("t6_fl_pend", 32'(pend1B), 32'd0);

        // Reset asserted mid-drain.
        lanes(1, 12, 32'h612, 1, 13, 32'h613); ra2A = 12;
        tick(); lanes(0, 0, 0, 0, 0, 0); drain_en = 1'b1; #1;
        chk("t6_pre_weA", 32'(weA), 32'd1);
        rst_n = 1'b0; #1;
        chk("t6_rst_weA", 32'(weA), 32'd0);
        chk("t6_rst_weB", 32'(weB), 32'd0);
        chk("t6_rst_cnt", 32'(count), 32'd0);
        chk("t6_rst_pend", 32'(pend2A), 32'd0);
        chk("t6_rst_rdy", 32'(in_ready), 32'd1);
        tick(); rst_n = 1'b1; tick(); #1;
        chk("t6_post_weA", 32'(weA), 32'd0);
        lanes(1, 14, 32'h714, 0, 0, 0);
        tick(); lanes(0, 0, 0, 0, 0, 0); #1;
        chk("t6_rec_waA", 32'(waA), 32'd14);
        chk("t6_rec_wdA", wdA, 32'h714);
        tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
